kersram_r: RTL and testbench

Kernel SRAM read sequencer: the stage directly downstream of the kernel SRAM write stage. After the write stage finishes filling the eight kernel SRAMs, this block reads all eight in lock-step, address 0..KER_ST_LENGTH-1. It replays that sweep a configurable number of passes and streams 8×64-bit kernel words to the PE array over a valid/ready handshake. A 2-entry output buffer absorbs the 1-cycle SRAM read latency, so consumer backpressure never drops data.

---
 rtl/kersr_pkg.sv | 18 +
 rtl/count_yi_v3.sv | 23 ++
 rtl/kersram_r_obuf.sv | 55 +++++
 rtl/kersram_r.sv | 133 +++++++++++++
 tb/tb_kersram_r.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/kersr_pkg.sv
// Shared constants and FSM encoding for the kernel SRAM read path.
package kersr_pkg;

  localparam int unsigned KER_SRAM_NUM  = 8;
  localparam int unsigned ADDR_CNT_BITS = 11;
  localparam int unsigned DATA_BITS     = 64;
  localparam int unsigned KER_ST_LENGTH = 288;
  localparam int unsigned PASS_BITS     = 8;
  localparam int unsigned KER_WORD_BITS = KER_SRAM_NUM * DATA_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } kr_state_t;

endpackage

// File: rtl/count_yi_v3.sv
// Wrapping up-counter 0..final_number-1 with synchronous clear.
module count_yi_v3 #(
  parameter int unsigned BITS_OF_END_NUMBER = 11,
  parameter int unsigned final_number       = 288
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          enable,
  output logic [BITS_OF_END_NUMBER-1:0] count,
  output logic                          last_c
);

  assign last_c = (count == BITS_OF_END_NUMBER'(final_number - 1));

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (enable)
      count <= last_c ? '0 : count + BITS_OF_END_NUMBER'(1);
  end

endmodule

// File: rtl/kersram_r_obuf.sv
// Two-entry FIFO holding SRAM read beats; entry 0 is always the head.
module kersram_r_obuf import kersr_pkg::*; #(
  parameter int unsigned WIDTH = KER_WORD_BITS + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] ent0_q, ent1_q;
  logic [1:0]       occ_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) ent0_q <= din;
          else               ent1_q <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          // Head leaves; the new beat lands behind whatever remains.
          if (occ_q == 2'd2) begin
            ent0_q <= ent1_q;
            ent1_q <= din;
          end else begin
            ent0_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = ent0_q;
  assign valid = (occ_q != 2'd0);
  assign occ   = occ_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (occ_q == 2'd2)));

endmodule

// File: rtl/kersram_r.sv
// Kernel SRAM read sequencer: sweeps all eight SRAMs in lock-step for N passes
// and streams the words to the PE array through a 2-deep skid buffer.
module kersram_r #(
  parameter int unsigned ADDR_CNT_BITS = kersr_pkg::ADDR_CNT_BITS,
  parameter int unsigned KER_ST_LENGTH = kersr_pkg::KER_ST_LENGTH,
  parameter int unsigned DATA_BITS     = kersr_pkg::DATA_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_ker_read,
  input  logic [7:0]               cfg_ker_pass,
  output logic                     ker_read_busy,
  output logic                     ker_read_done,
  output logic                     cen_kersr_0, cen_kersr_1, cen_kersr_2, cen_kersr_3,
  output logic                     cen_kersr_4, cen_kersr_5, cen_kersr_6, cen_kersr_7,
  output logic                     wen_kersr_0, wen_kersr_1, wen_kersr_2, wen_kersr_3,
  output logic                     wen_kersr_4, wen_kersr_5, wen_kersr_6, wen_kersr_7,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_0, addr_kersr_1, addr_kersr_2, addr_kersr_3,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_4, addr_kersr_5, addr_kersr_6, addr_kersr_7,
  input  logic [DATA_BITS-1:0]     dout_kersr_0, dout_kersr_1, dout_kersr_2, dout_kersr_3,
  input  logic [DATA_BITS-1:0]     dout_kersr_4, dout_kersr_5, dout_kersr_6, dout_kersr_7,
  output logic [DATA_BITS-1:0]     ker_read_data_0, ker_read_data_1, ker_read_data_2, ker_read_data_3,
  output logic [DATA_BITS-1:0]     ker_read_data_4, ker_read_data_5, ker_read_data_6, ker_read_data_7,
  output logic                     ker_read_valid,
  input  logic                     ker_read_ready,
  output logic                     ker_read_last
);
  import kersr_pkg::*;

  localparam int unsigned BEAT_BITS = KER_SRAM_NUM * DATA_BITS + 1;

  kr_state_t                state_q, state_d;
  logic                     inflight_q, inflight_last_q;
  logic [PASS_BITS-1:0]     pass_ct_q, pass_max_q;
  logic [ADDR_CNT_BITS-1:0] addr_ct;
  logic                     addr_last_c;
  logic [1:0]               occ;
  logic                     pop, issue, final_pass, drain_empty;
  logic [BEAT_BITS-1:0]     push_beat, head_beat;
  logic [ADDR_CNT_BITS-1:0] rd_addr;

  // Issue only if this read, plus everything buffered or in flight, still fits.
  assign pop         = ker_read_valid & ker_read_ready;
  assign issue       = (state_q == RUN) &&
                       (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
  assign final_pass  = (pass_ct_q == pass_max_q - PASS_BITS'(1));
  assign drain_empty = !inflight_q && ((occ == 2'd0) || ((occ == 2'd1) && pop));

  count_yi_v3 #(
    .BITS_OF_END_NUMBER (ADDR_CNT_BITS),
    .final_number       (KER_ST_LENGTH)
  ) u_addr_ct (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == IDLE),
    .enable (issue),
    .count  (addr_ct),
    .last_c (addr_last_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      pass_ct_q       <= '0;
      pass_max_q      <= PASS_BITS'(1);
    end else begin
      state_q         <= state_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && addr_last_c;
      if ((state_q == IDLE) && start_ker_read) begin
        pass_ct_q  <= '0;
        pass_max_q <= (cfg_ker_pass == '0) ? PASS_BITS'(1) : cfg_ker_pass;
      end else if (issue && addr_last_c) begin
        pass_ct_q <= pass_ct_q + PASS_BITS'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ker_read) state_d = RUN;
      RUN:     if (issue && addr_last_c && final_pass) state_d = DRAIN;
      DRAIN:   if (drain_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  kersram_r_obuf #(.WIDTH(BEAT_BITS)) u_obuf (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .din   (push_beat),
    .dout  (head_beat),
    .valid (ker_read_valid),
    .occ   (occ)
  );

  assign push_beat = {inflight_last_q, dout_kersr_7, dout_kersr_6, dout_kersr_5, dout_kersr_4,
                      dout_kersr_3, dout_kersr_2, dout_kersr_1, dout_kersr_0};

  assign ker_read_data_0 = head_beat[0*DATA_BITS +: DATA_BITS];
  assign ker_read_data_1 = head_beat[1*DATA_BITS +: DATA_BITS];
  assign ker_read_data_2 = head_beat[2*DATA_BITS +: DATA_BITS];
  assign ker_read_data_3 = head_beat[3*DATA_BITS +: DATA_BITS];
  assign ker_read_data_4 = head_beat[4*DATA_BITS +: DATA_BITS];
  assign ker_read_data_5 = head_beat[5*DATA_BITS +: DATA_BITS];
  assign ker_read_data_6 = head_beat[6*DATA_BITS +: DATA_BITS];
  assign ker_read_data_7 = head_beat[7*DATA_BITS +: DATA_BITS];
  assign ker_read_last   = ker_read_valid & head_beat[BEAT_BITS-1];

  assign ker_read_busy = (state_q == RUN) || (state_q == DRAIN);
  assign ker_read_done = (state_q == DONE);

  assign rd_addr = issue ? addr_ct : '0;
  assign {cen_kersr_7, cen_kersr_6, cen_kersr_5, cen_kersr_4,
          cen_kersr_3, cen_kersr_2, cen_kersr_1, cen_kersr_0} = {8{~issue}};
  assign {wen_kersr_7, wen_kersr_6, wen_kersr_5, wen_kersr_4,
          wen_kersr_3, wen_kersr_2, wen_kersr_1, wen_kersr_0} = 8'hFF;
  assign addr_kersr_0 = rd_addr;
  assign addr_kersr_1 = rd_addr;
  assign addr_kersr_2 = rd_addr;
  assign addr_kersr_3 = rd_addr;
  assign addr_kersr_4 = rd_addr;
  assign addr_kersr_5 = rd_addr;
  assign addr_kersr_6 = rd_addr;
  assign addr_kersr_7 = rd_addr;

endmodule

// File: tb/tb_kersram_r.sv
// Directed bench for kersram_r: SRAM model, expected-beat scoreboard, timing checks.
module tb_kersram_r;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s[2], start_s[2], ready_s[2];
  logic [7:0]  cfg_s[2];
  logic        busy_s[2], done_s[2], valid_s[2], last_s[2];
  logic        cen_s[2][8], wen_s[2][8];
  logic [10:0] addr_s[2][8];
  logic [63:0] dout_s[2][8], data_s[2][8];

  int n_asserts = 0;
  int n_fail    = 0;

  kersram_r u_dut0 (
    .clk(clk), .reset(rst_s[0]), .start_ker_read(start_s[0]), .cfg_ker_pass(cfg_s[0]),
    .ker_read_busy(busy_s[0]), .ker_read_done(done_s[0]),
    .cen_kersr_0(cen_s[0][0]), .cen_kersr_1(cen_s[0][1]), .cen_kersr_2(cen_s[0][2]), .cen_kersr_3(cen_s[0][3]),
    .cen_kersr_4(cen_s[0][4]), .cen_kersr_5(cen_s[0][5]), .cen_kersr_6(cen_s[0][6]), .cen_kersr_7(cen_s[0][7]),
    .wen_kersr_0(wen_s[0][0]), .wen_kersr_1(wen_s[0][1]), .wen_kersr_2(wen_s[0][2]), .wen_kersr_3(wen_s[0][3]),
    .wen_kersr_4(wen_s[0][4]), .wen_kersr_5(wen_s[0][5]), .wen_kersr_6(wen_s[0][6]), .wen_kersr_7(wen_s[0][7]),
    .addr_kersr_0(addr_s[0][0]), .addr_kersr_1(addr_s[0][1]), .addr_kersr_2(addr_s[0][2]), .addr_kersr_3(addr_s[0][3]),
    .addr_kersr_4(addr_s[0][4]), .addr_kersr_5(addr_s[0][5]), .addr_kersr_6(addr_s[0][6]), .addr_kersr_7(addr_s[0][7]),
    .dout_kersr_0(dout_s[0][0]), .dout_kersr_1(dout_s[0][1]), .dout_kersr_2(dout_s[0][2]), .dout_kersr_3(dout_s[0][3]),
    .dout_kersr_4(dout_s[0][4]), .dout_kersr_5(dout_s[0][5]), .dout_kersr_6(dout_s[0][6]), .dout_kersr_7(dout_s[0][7]),
    .ker_read_data_0(data_s[0][0]), .ker_read_data_1(data_s[0][1]), .ker_read_data_2(data_s[0][2]), .ker_read_data_3(data_s[0][3]),
    .ker_read_data_4(data_s[0][4]), .ker_read_data_5(data_s[0][5]), .ker_read_data_6(data_s[0][6]), .ker_read_data_7(data_s[0][7]),
    .ker_read_valid(valid_s[0]), .ker_read_ready(ready_s[0]), .ker_read_last(last_s[0])
  );

  kersram_r #(.KER_ST_LENGTH(1)) u_dut1 (
    .clk(clk), .reset(rst_s[1]), .start_ker_read(start_s[1]), .cfg_ker_pass(cfg_s[1]),
    .ker_read_busy(busy_s[1]), .ker_read_done(done_s[1]),
    .cen_kersr_0(cen_s[1][0]), .cen_kersr_1(cen_s[1][1]), .cen_kersr_2(cen_s[1][2]), .cen_kersr_3(cen_s[1][3]),
    .cen_kersr_4(cen_s[1][4]), .cen_kersr_5(cen_s[1][5]), .cen_kersr_6(cen_s[1][6]), .cen_kersr_7(cen_s[1][7]),
    .wen_kersr_0(wen_s[1][0]), .wen_kersr_1(wen_s[1][1]), .wen_kersr_2(wen_s[1][2]), .wen_kersr_3(wen_s[1][3]),
    .wen_kersr_4(wen_s[1][4]), .wen_kersr_5(wen_s[1][5]), .wen_kersr_6(wen_s[1][6]), .wen_kersr_7(wen_s[1][7]),
    .addr_kersr_0(addr_s[1][0]), .addr_kersr_1(addr_s[1][1]), .addr_kersr_2(addr_s[1][2]), .addr_kersr_3(addr_s[1][3]),
    .addr_kersr_4(addr_s[1][4]), .addr_kersr_5(addr_s[1][5]), .addr_kersr_6(addr_s[1][6]), .addr_kersr_7(addr_s[1][7]),
    .dout_kersr_0(dout_s[1][0]), .dout_kersr_1(dout_s[1][1]), .dout_kersr_2(dout_s[1][2]), .dout_kersr_3(dout_s[1][3]),
    .dout_kersr_4(dout_s[1][4]), .dout_kersr_5(dout_s[1][5]), .dout_kersr_6(dout_s[1][6]), .dout_kersr_7(dout_s[1][7]),
    .ker_read_data_0(data_s[1][0]), .ker_read_data_1(data_s[1][1]), .ker_read_data_2(data_s[1][2]), .ker_read_data_3(data_s[1][3]),
    .ker_read_data_4(data_s[1][4]), .ker_read_data_5(data_s[1][5]), .ker_read_data_6(data_s[1][6]), .ker_read_data_7(data_s[1][7]),
    .ker_read_valid(valid_s[1]), .ker_read_ready(ready_s[1]), .ker_read_last(last_s[1])
  );

  function automatic logic [63:0] lane_word(input int i, input logic [10:0] a);
    return (64'(i) << 32) | 64'(a);
  endfunction

  // Synchronous-read SRAM model: word = {sram index, address}
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++)
        if (cen_s[d][i] === 1'b0) dout_s[d][i] <= lane_word(i, addr_s[d][i]);

  function automatic logic [511:0] exp_word(input int a);
    logic [511:0] w;
    for (int i = 0; i < 8; i++) w[i*64 +: 64] = lane_word(i, 11'(a));
    return w;
  endfunction

  function automatic logic [511:0] obs_word(input int d);
    logic [511:0] w;
    for (int i = 0; i < 8; i++) w[i*64 +: 64] = data_s[d][i];
    return w;
  endfunction

  function automatic logic [7:0] cen_vec(input int d);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = cen_s[d][i];
    return v;
  endfunction

  function automatic logic [7:0] wen_vec(input int d);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = wen_s[d][i];
    return v;
  endfunction

  function automatic logic [87:0] addr_vec(input int d);
    logic [87:0] v;
    for (int i = 0; i < 8; i++) v[i*11 +: 11] = addr_s[d][i];
    return v;
  endfunction

  function automatic logic [87:0] addr_rep(input int a);
    logic [87:0] v;
    for (int i = 0; i < 8; i++) v[i*11 +: 11] = 11'(a);
    return v;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before sampling.
  task automatic step(input int d, input logic st, input logic rdy, input logic rs);
    @(negedge clk);
    start_s[d] = st;
    ready_s[d] = rdy;
    rst_s[d]   = rs;
    #1;
  endtask

  // mode: 0 ready high, 1 random ready, 2 stall 20 cycles after first beat
  task automatic run_job(input int d, input int cfg, input int mode,
                         input int reset_at, input int mid_start);
    int L, total, cyc, issued, popped, first_valid, stall_left, a;
    int exp_q[$];
    bit rdy, release_chk;
    L     = (d == 0) ? 288 : 1;
    total = ((cfg == 0) ? 1 : cfg) * L;
    for (int k = 0; k < total; k++) exp_q.push_back(k % L);
    cfg_s[d] = 8'(cfg);
    issued = 0; popped = 0; first_valid = -1; stall_left = -1; release_chk = 0;

    cyc = 0;
    step(d, 1'b1, 1'b1, 1'b0);
    check("idle_busy", 512'(busy_s[d]), 512'(0));
    check("idle_done", 512'(done_s[d]), 512'(0));
    check("idle_cen", 512'(cen_vec(d)), 512'(8'hFF));

    while (exp_q.size() > 0) begin
      cyc++;
      if (cyc > 5000) begin
        check("cycle_budget", 512'(cyc), 512'(5000));
        return;
      end
      rdy = 1'b1;
      if (mode == 1) rdy = 1'($urandom_range(0, 1));
      if (mode == 2 && stall_left > 0) rdy = 1'b0;

      if (reset_at >= 0 && popped == reset_at) begin
        step(d, 1'b0, 1'b1, 1'b1);
        step(d, 1'b0, 1'b1, 1'b0);
        check("rst_valid", 512'(valid_s[d]), 512'(0));
        check("rst_busy", 512'(busy_s[d]), 512'(0));
        check("rst_cen", 512'(cen_vec(d)), 512'(8'hFF));
        check("rst_done", 512'(done_s[d]), 512'(0));
        return;
      end

      step(d, 1'(cyc == mid_start), rdy, 1'b0);
      check("done_early", 512'(done_s[d]), 512'(0));
      if (cyc == 1) begin
        check("busy_c1", 512'(busy_s[d]), 512'(1));
        check("cen_c1", 512'(cen_vec(d)), 512'(8'h00));
      end
      if (first_valid < 0 && valid_s[d]) begin
        first_valid = cyc;
        check("first_valid_cycle", 512'(cyc), 512'(3));
      end
      if (cen_vec(d) == 8'h00) begin
        check("issue_addr", 512'(addr_vec(d)), 512'(addr_rep(issued % L)));
        issued++;
      end
      if (mode == 0 && first_valid >= 0) check("no_bubble", 512'(valid_s[d]), 512'(1));
      if (release_chk) begin
        check("resume_valid", 512'(valid_s[d]), 512'(1));
        release_chk = 0;
      end
      if (mode == 2 && stall_left > 0) begin
        check("stall_cen", 512'(cen_vec(d)), 512'(8'hFF));
        check("stall_valid", 512'(valid_s[d]), 512'(1));
        stall_left--;
        release_chk = (stall_left == 0);
      end
      if (valid_s[d] && rdy) begin
        a = exp_q.pop_front();
        check("beat_data", obs_word(d), exp_word(a));
        check("beat_last", 512'(last_s[d]), 512'(a == L - 1));
        popped++;
        if (mode == 2 && popped == 1) stall_left = 20;
      end
      check("outstanding_le2", 512'(issued - popped <= 2), 512'(1));
    end

    step(d, 1'b0, 1'b1, 1'b0);
    check("done_pulse", 512'(done_s[d]), 512'(1));
    check("done_busy", 512'(busy_s[d]), 512'(0));
    check("done_valid", 512'(valid_s[d]), 512'(0));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; start_s[d] = 1'b0; ready_s[d] = 1'b0; cfg_s[d] = 8'd0;
    end
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1);
    check("rv_busy", 512'(busy_s[0]), 512'(0));
    check("rv_done", 512'(done_s[0]), 512'(0));
    check("rv_valid", 512'(valid_s[0]), 512'(0));
    check("rv_last", 512'(last_s[0]), 512'(0));
    check("rv_data", obs_word(0), 512'(0));
    check("rv_cen", 512'(cen_vec(0)), 512'(8'hFF));
    check("rv_wen", 512'(wen_vec(0)), 512'(8'hFF));
    check("rv_addr", 512'(addr_vec(0)), 512'(0));
    rst_s[1] = 1'b0;
    step(0, 1'b0, 1'b0, 1'b0);

    run_job(0, 1, 0, -1, -1);   // single pass
    run_job(0, 3, 0, -1, -1);   // three passes, wrap 287->0
    run_job(0, 0, 0, -1, -1);   // zero treated as one
    run_job(0, 2, 1, -1, -1);   // random backpressure
    run_job(0, 1, 2, -1, -1);   // 20-cycle stall
    run_job(0, 1, 0, -1, 50);   // stray start mid-job
    run_job(0, 1, 0, 100, -1);  // reset at beat 100
    run_job(0, 1, 0, -1, -1);   // restart from address 0
    step(0, 1'b0, 1'b1, 1'b0);
    check("done_single", 512'(done_s[0]), 512'(0));

    run_job(1, 4, 0, -1, -1);   // one-word SRAM, four passes
    step(1, 1'b0, 1'b1, 1'b0);
    check("done_single_l1", 512'(done_s[1]), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
